bg_name_scheduler: RTL and testbench

- Sequences access to the single-port, double-banked background name RAM.
- Two requesters share it:
  - the pixel fetch path, which has absolute priority in the visible region;
  - a game-logic write port, queued in a small FIFO and drained only during blanking.
- Owns the active-bank select and performs bank swaps at a frame-safe point, so game logic can rebuild the back bank without tearing.

---
 rtl/bg_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/bg_name_scheduler.sv | 141 ++++++++++++++
 tb/tb_bg_name_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bg_pkg
// Description : Shared constants and types for the background name-table
//               path: visible-region limits, name-table geometry and the
//               queued write entry format.
// Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

    // First non-visible pixel column / row of the display timing.
    localparam int VIS_W       = 320;
    localparam int VIS_H       = 239;

    // Name table: 64x32 tiles per bank, one tile index per slot.
    localparam int NAME_ADDR_W = 11;
    localparam int TILE_W      = 8;

    // One queued game-logic write to the back bank.
    typedef struct packed {
        logic [NAME_ADDR_W-1:0] addr;
        logic [TILE_W-1:0]      data;
    } name_wr_t;

endpackage : bg_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular-buffer FIFO with occupancy counter.
//               Push is dropped when full, pop is dropped when empty.
//               Simultaneous push and pop leave the count unchanged.
//               dout always presents the current head (first-word
//               fall-through).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, din       - write strobe and data
//               pop, dout       - read strobe and head data
//               count           - entries held (0..DEPTH)
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4            // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly PTR_W bits wide, so the increment wraps modulo
    // DEPTH on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/bg_name_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bg_name_scheduler
// Description : Arbitrates the single-port, double-banked background name
//               RAM between the pixel fetch path (owns the port during the
//               visible region) and a queued game-logic write port (drained
//               only in blanking, always into the back bank). Holds the
//               front-bank select and swaps banks only in vertical blank
//               once every queued write has landed.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               pixel_x, pixel_y         - current raster position
//               wr_valid/addr/data/ready - game-logic write handshake
//               swap_req                 - one-cycle bank swap request
//               ram_addr/we/wdata        - name RAM port ({bank, addr})
//               active                   - current front (display) bank
//               swap_pending             - swap latched, not yet applied
//               fifo_count               - queued writes
// Revision    : 1.0 - initial release
// ============================================================================
module bg_name_scheduler
    import bg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = bg_pkg::NAME_ADDR_W,
    parameter int DATA_W     = bg_pkg::TILE_W,
    parameter int VIS_W      = bg_pkg::VIS_W,
    parameter int VIS_H      = bg_pkg::VIS_H
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8:0]                    pixel_x,
    input  logic [7:0]                    pixel_y,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          swap_req,
    output logic [ADDR_W:0]               ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          active,
    output logic                          swap_pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [8:0] c_vis_w = 9'(VIS_W);
    localparam logic [7:0] c_vis_h = 8'(VIS_H);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    logic              w_visible;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    name_wr_t          w_push_ent;
    name_wr_t          w_head;
    logic              w_apply;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_active;
    logic              w_active_nxt;

    assign w_visible = (pixel_x < c_vis_w) && (pixel_y < c_vis_h);
    // One name slot per 8x8 tile: row = y/8, column = x/8.
    assign w_rd_addr = ADDR_W'({pixel_y[7:3], pixel_x[8:3]});

    assign wr_ready        = !rst && !w_full;
    assign w_push          = wr_valid && wr_ready;
    // Pop is gated by rst so no write can leak out while reset is held.
    assign w_pop           = !rst && !w_visible && !w_empty;
    assign w_push_ent.addr = wr_addr;
    assign w_push_ent.data = wr_data;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_ent),
        .dout  (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // RAM port mux: the write slot exists exactly when the head is popped.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {r_active, w_rd_addr};
        ram_wdata = '0;
        if (w_pop) begin
            ram_we    = 1'b1;
            ram_addr  = {~r_active, w_head.addr};
            ram_wdata = w_head.data;
        end
    end

    // A push on the apply cycle would land after the swap, in the new front
    // bank, so it blocks the swap for that cycle.
    assign w_apply = (r_state == S_PENDING) && (pixel_y >= c_vis_h)
                     && w_empty && !w_push;

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        case (r_state)
            S_IDLE: begin
                if (swap_req) w_state_nxt = S_PENDING;
            end
            S_PENDING: begin
                // A repeated request while pending is absorbed here.
                if (w_apply) begin
                    w_state_nxt  = S_IDLE;
                    w_active_nxt = ~r_active;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign active       = r_active;
    assign swap_pending = (r_state == S_PENDING);

endmodule : bg_name_scheduler
`default_nettype wire

// File: tb/tb_bg_name_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_name_scheduler
// Description : Self-checking bench for bg_name_scheduler. Directed scenario
//               tasks followed by a randomized run against a queue-based
//               reference model of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_name_scheduler;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [8:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic        wr_valid;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        swap_req;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic        active;
    logic        swap_pending;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    bg_name_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (11),
        .DATA_W     (8),
        .VIS_W      (320),
        .VIS_H      (239)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .swap_req     (swap_req),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .active       (active),
        .swap_pending (swap_pending),
        .fifo_count   (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int a;
        int d;
    } ent_t;

    ent_t q[$];
    int   m_act  = 0;
    int   m_pend = 0;

    logic        exp_we;
    logic        exp_ready;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;

    function automatic bit m_visible();
        return (int'(pixel_x) < 320) && (int'(pixel_y) < 239);
    endfunction

    function automatic void model_comb();
        exp_ready = !rst && (q.size() < DEPTH);
        exp_we    = !rst && !m_visible() && (q.size() > 0);
        if (exp_we) begin
            exp_addr  = 12'((1 - m_act) * 2048 + q[0].a);
            exp_wdata = 8'(q[0].d);
        end else begin
            exp_addr  = 12'(m_act * 2048 + (int'(pixel_y) / 8) * 64 + int'(pixel_x) / 8);
            exp_wdata = 8'd0;
        end
    endfunction

    function automatic void model_edge();
        bit   pop, push, apply;
        ent_t e;
        if (rst) begin
            q.delete();
            m_act  = 0;
            m_pend = 0;
            return;
        end
        pop   = !m_visible() && (q.size() > 0);
        push  = wr_valid && (q.size() < DEPTH);
        apply = (m_pend != 0) && (int'(pixel_y) >= 239) && (q.size() == 0) && !push;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.a = int'(wr_addr);
            e.d = int'(wr_data);
            q.push_back(e);
        end
        if (apply) begin
            m_act  = 1 - m_act;
            m_pend = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
    endfunction

    // One clock: DUT and model both take the edge, then return to the
    // falling edge where inputs are changed and outputs sampled.
    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; pixel_x = 9'd10; pixel_y = 8'd10;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        @(negedge clk);
        advance();
        advance();
        #1;
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
        rst = 1'b0;
        #1;
        total++; if (ram_addr !== 12'h041) begin bad++; $display("FAIL reset_addr: got %h want 041", ram_addr); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we2: got %b want 0", ram_we); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready2: got %b want 1", wr_ready); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL reset_pend: got %b want 0", swap_pending); end
        advance();
    endtask

    task automatic test_drain();
        pixel_x = 9'd100; pixel_y = 8'd50;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 11'(5 + i); wr_data = 8'(8'hA1 + i);
            advance();
        end
        wr_valid = 1'b0;
        #1;
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL drain_count: got %0d want 3", fifo_count); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL drain_vis_we: got %b want 0", ram_we); end
        pixel_x = 9'd320;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL drain_we[%0d]: got %b want 1", i, ram_we); end
            total++; if (ram_addr !== 12'(12'h805 + i)) begin bad++; $display("FAIL drain_addr[%0d]: got %h want %h", i, ram_addr, 12'(12'h805 + i)); end
            total++; if (ram_wdata !== 8'(8'hA1 + i)) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, ram_wdata, 8'(8'hA1 + i)); end
            advance();
        end
        #1;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", fifo_count); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL drain_done_we: got %b want 0", ram_we); end
    endtask

    task automatic test_back_to_back();
        pixel_x = 9'd100; pixel_y = 8'd50;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_addr = 11'(11'h100 + i); wr_data = 8'(8'h10 + i);
            #1;
            total++; if (wr_ready !== (i < 4)) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, wr_ready, (i < 4)); end
            if (i < 4) advance();
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_full: got %0d want 4", fifo_count); end
        pixel_x = 9'd330;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 12'h900) begin bad++; $display("FAIL b2b_pop0: got we=%b addr=%h want we=1 addr=900", ram_we, ram_addr); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_fullpop: got %b want 0", wr_ready); end
        advance();
        #1;
        total++; if (fifo_count !== 3'd3 || wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_after_pop: got count=%0d ready=%b want 3/1", fifo_count, wr_ready); end
        total++; if (ram_addr !== 12'h901) begin bad++; $display("FAIL b2b_pop1: got %h want 901", ram_addr); end
        advance();
        wr_valid = 1'b0;
        #1;
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL b2b_pushpop: got %0d want 3", fifo_count); end
        for (int j = 2; j < 5; j++) begin
            #1;
            total++; if (ram_addr !== 12'(12'h900 + j) || ram_wdata !== 8'(8'h10 + j)) begin
                bad++; $display("FAIL b2b_pop%0d: got addr=%h data=%h want %h/%h", j, ram_addr, ram_wdata, 12'(12'h900 + j), 8'(8'h10 + j));
            end
            advance();
        end
        #1;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_swap();
        pixel_x = 9'd0; pixel_y = 8'd100; swap_req = 1'b1;
        #1;
        total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL swap_early: got %b want 0", swap_pending); end
        advance();
        swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (swap_pending !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL swap_hold[%0d]: got pend=%b act=%b want 1/0", i, swap_pending, active); end
            advance();
        end
        pixel_y = 8'd239;
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL swap_preapply: got %b want 0", active); end
        advance();
        #1;
        total++; if (active !== 1'b1 || swap_pending !== 1'b0) begin bad++; $display("FAIL swap_apply: got act=%b pend=%b want 1/0", active, swap_pending); end
        pixel_x = 9'd10; pixel_y = 8'd10;
        #1;
        total++; if (ram_addr !== 12'h841) begin bad++; $display("FAIL swap_read_bank: got %h want 841", ram_addr); end
        advance();
    endtask

    task automatic test_swap_with_queue();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        pixel_x = 9'd100; pixel_y = 8'd50;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_addr = 11'(11'h020 + i); wr_data = 8'(8'h55 + i);
            advance();
        end
        wr_valid = 1'b0; swap_req = 1'b1;
        advance();
        swap_req = 1'b0;
        pixel_x = 9'd0; pixel_y = 8'd239;
        #1;
        total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL swq_pend: got %b want 1", swap_pending); end
        total++; if (ram_we !== 1'b1 || ram_addr !== 12'h820) begin bad++; $display("FAIL swq_w0: got we=%b addr=%h want 1/820", ram_we, ram_addr); end
        advance();
        swap_req = 1'b1;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 12'h821 || active !== 1'b0) begin bad++; $display("FAIL swq_w1: got we=%b addr=%h act=%b want 1/821/0", ram_we, ram_addr, active); end
        advance();
        swap_req = 1'b0;
        #1;
        total++; if (active !== 1'b0 || swap_pending !== 1'b1 || fifo_count !== 3'd0) begin bad++; $display("FAIL swq_wait: got act=%b pend=%b cnt=%0d want 0/1/0", active, swap_pending, fifo_count); end
        advance();
        #1;
        total++; if (active !== 1'b1 || swap_pending !== 1'b0) begin bad++; $display("FAIL swq_apply: got act=%b pend=%b want 1/0", active, swap_pending); end
        advance();
        advance();
        #1;
        total++; if (active !== 1'b1 || swap_pending !== 1'b0) begin bad++; $display("FAIL swq_no_retoggle: got act=%b pend=%b want 1/0", active, swap_pending); end
    endtask

    task automatic test_rst_mid_drain();
        pixel_x = 9'd100; pixel_y = 8'd50;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 11'(11'h300 + i); wr_data = 8'(i);
            advance();
        end
        wr_valid = 1'b0;
        pixel_x = 9'd320;
        advance();
        #1;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rstd_count: got %0d want 2", fifo_count); end
        rst = 1'b1;
        #1;
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rstd_we: got %b want 0", ram_we); end
        advance();
        rst = 1'b0;
        #1;
        total++; if (fifo_count !== 3'd0 || active !== 1'b0 || swap_pending !== 1'b0) begin bad++; $display("FAIL rstd_after: got cnt=%0d act=%b pend=%b want 0/0/0", fifo_count, active, swap_pending); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rstd_after_we: got %b want 0", ram_we); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst      = ($urandom_range(0, 149) == 0);
            pixel_x  = 9'($urandom_range(0, 399));
            pixel_y  = 8'($urandom_range(0, 255));
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 11'($urandom);
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 7) == 0);
            #1;
            model_comb();
            total++; if (ram_we !== exp_we || ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
                bad++; $display("FAIL rnd_port[%0d]: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", c, ram_we, ram_addr, ram_wdata, exp_we, exp_addr, exp_wdata);
            end
            total++; if (wr_ready !== exp_ready || int'(fifo_count) != q.size()) begin
                bad++; $display("FAIL rnd_fifo[%0d]: got ready=%b cnt=%0d want ready=%b cnt=%0d", c, wr_ready, fifo_count, exp_ready, q.size());
            end
            total++; if (int'(active) != m_act || int'(swap_pending) != m_pend) begin
                bad++; $display("FAIL rnd_swap[%0d]: got act=%b pend=%b want act=%0d pend=%0d", c, active, swap_pending, m_act, m_pend);
            end
            advance();
        end
        rst = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_back_to_back();
        test_swap();
        test_swap_with_queue();
        test_rst_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bg_name_scheduler
`default_nettype wire
